fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin write arbiter that shares one synchronous FIFO write port among NREQ ready/valid producers. It sits directly in front of the FIFO and grants one requester at a time for a burst. A burst ends on the requester's `last` beat or after MAX_BURST accepted beats. The FIFO's `full` flag is the only back-pressure source, so the FIFO never overflows and beats from different requesters never interleave within a burst.

## Interface
- DATA_WIDTH, 8, width of each requester's data and of the FIFO write data
- NREQ, 4, number of requesters (2..16)
- MAX_BURST, 16, maximum accepted beats per grant (1..256)
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- req_valid  in  NREQ  per-requester beat valid
- req_data  in  NREQ*DATA_WIDTH  per-requester data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_last  in  NREQ  marks the final beat of a requester's packet
- req_ready  out  NREQ  per-requester beat accepted when high together with valid
- fifo_full  in  1  FIFO full flag
- fifo_wr_en  out  1  FIFO write strobe
- fifo_wr_data  out  DATA_WIDTH  FIFO write data
- gnt_valid  out  1  a grant is active (state BURST)
- gnt_id  out  $clog2(NREQ)  index of the granted requester; 0 when no grant is active

## Operation
- States: IDLE and BURST. Registers: state, gnt_id, rr_ptr ($clog2(NREQ) bits), beat_cnt ($clog2(MAX_BURST+1) bits).
- IDLE:
  - If any req_valid is high, select the first requester with valid high, searching upward from rr_ptr with wrap modulo NREQ.
  - Register it into gnt_id, clear beat_cnt, and go to BURST.
  - No beats are accepted in IDLE.
- BURST:
  - Beat accepted = req_valid[gnt_id] && !fifo_full.
  - req_ready[gnt_id] = !fifo_full. All other req_ready bits are 0.
  - fifo_wr_en = beat accepted. fifo_wr_data = req_data slice of gnt_id. Both are combinational from the current inputs.
  - On an accepted beat, beat_cnt increments.
- Release:
  - Release happens on an accepted beat with req_last high, or on an accepted beat that makes beat_cnt reach MAX_BURST.
  - On release: state goes to IDLE, rr_ptr = (gnt_id+1) mod NREQ, and gnt_id clears to 0.
- The grant is held while the grantee's valid is low or fifo_full is high. No timeout, no preemption.
- The producer protocol is AXI-style: once valid is asserted, it stays high with data stable until ready. The arbiter does not check this.
- fifo_full is sampled every BURST cycle, so no write is ever issued while fifo_full is high. This gives the no-overflow guarantee.
- Outside BURST: fifo_wr_en=0, req_ready=0, gnt_valid=0.

## Timing
- Reset values (applied at the rising edge with rst high): state=IDLE, rr_ptr=0, gnt_id=0, beat_cnt=0.
- While rst is high, req_ready, fifo_wr_en and gnt_valid are forced to 0 combinationally.
- Reset asserted mid-burst aborts the burst. No write occurs in the reset cycle, and arbitration restarts from rr_ptr=0.
- Arbitration latency:
  - A request seen in IDLE at edge N gives gnt_valid high after edge N.
  - The first beat can be accepted in the cycle after edge N.
  - Every burst is therefore followed by exactly one IDLE bubble cycle.
- Peak throughput: one beat per cycle within a burst. Aggregate throughput is MAX_BURST/(MAX_BURST+1) with continuous requests.
- Write latency is 0: fifo_wr_en is combinational in the same cycle as the producer handshake.
- Simultaneous req_last and the MAX_BURST-th beat is a single release.
- MAX_BURST=1 degenerates to per-beat round-robin.
- rr_ptr wraps from NREQ-1 to 0.
- A fifo_full rising in the same cycle as the last beat blocks that beat, and the grant is retained.

## Test plan
- Reset and idle:
  - Stimulus: rst high 3 cycles with all req_valid=1.
  - Required response: req_ready=0, fifo_wr_en=0 throughout; after release, the first grant goes to requester 0.
- Round-robin fairness:
  - Stimulus: NREQ=4, all requesters continuously valid, single-beat packets (last=1).
  - Required response: grant order 0,1,2,3,0,…; each write is separated by one idle cycle.
- Burst cap:
  - Stimulus: MAX_BURST=4; requester 2 sends 10 beats without last; requester 3 also valid.
  - Required response: 4 beats from requester 2, then requester 3, then requester 2 resumes at beat 5; data order is preserved.
- Back-pressure:
  - Stimulus: fifo_full high for 5 cycles mid-burst.
  - Required response: fifo_wr_en=0 and ready=0 for those 5 cycles, gnt_id unchanged, the stalled beat is written once fifo_full drops, and no beat is lost or duplicated.
- Sparse grantee:
  - Stimulus: the granted requester drops valid for 3 cycles between beats while others request.
  - Required response: the grant is held, with no writes for those 3 cycles.
- Reset mid-burst:
  - Stimulus: rst asserted after beat 2 of requester 1.
  - Required response: no write in the reset cycle; the next grant searches from requester 0.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// Round-robin write arbiter sharing one synchronous FIFO write port among NREQ
// ready/valid producers. One requester at a time owns the port for a burst.
// A burst ends on that requester's last beat or after MAX_BURST accepted beats.
// fifo_full is the only back-pressure source.
//
// Ports:
//   clk, rst       single rising-edge clock, synchronous active-high reset
//   req_valid      per-requester beat valid
//   req_data       per-requester data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_last       per-requester final-beat marker
//   req_ready      per-requester accept; only the grantee can be ready
//   fifo_full      FIFO full flag
//   fifo_wr_en     FIFO write strobe (combinational with the producer handshake)
//   fifo_wr_data   FIFO write data (grantee's data slice)
//   gnt_valid      a burst grant is active
//   gnt_id         index of the granted requester, 0 when no grant is active
module fifo_wr_arbiter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NREQ       = 4,
  parameter int unsigned MAX_BURST  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NREQ-1:0]              req_valid,
  input  logic [NREQ*DATA_WIDTH-1:0]   req_data,
  input  logic [NREQ-1:0]              req_last,
  output logic [NREQ-1:0]              req_ready,
  input  logic                         fifo_full,
  output logic                         fifo_wr_en,
  output logic [DATA_WIDTH-1:0]        fifo_wr_data,
  output logic                         gnt_valid,
  output logic [$clog2(NREQ)-1:0]      gnt_id
);

  localparam int unsigned IdW    = $clog2(NREQ);
  localparam int unsigned IdExtW = IdW + 1;
  localparam int unsigned CntW   = $clog2(MAX_BURST + 1);

  // beat_cnt value at which the next accepted beat is the MAX_BURST-th one.
  localparam logic [CntW-1:0] LastBeatCnt = CntW'(MAX_BURST - 1);
  localparam logic [IdW-1:0]  LastId      = IdW'(NREQ - 1);

  typedef enum logic {
    StIdle,
    StBurst
  } state_e;

  state_e          state_q;
  logic [IdW-1:0]  gnt_id_q;
  logic [IdW-1:0]  rr_ptr_q;
  logic [CntW-1:0] beat_cnt_q;

  logic            sel_found;
  logic [IdW-1:0]  sel_id;
  logic [IdExtW-1:0] cand;

  logic            in_burst;
  logic            grantee_valid;
  logic            grantee_last;
  logic            beat_acc;
  logic            burst_done;

  // Round-robin search: first valid requester at or above rr_ptr, wrapping
  // modulo NREQ. The extra bit on cand keeps the wrap correct for NREQ that
  // is not a power of two.
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    cand      = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      cand = {1'b0, rr_ptr_q} + IdExtW'(i);
      if (cand >= IdExtW'(NREQ)) begin
        cand = cand - IdExtW'(NREQ);
      end
      if (!sel_found && req_valid[cand[IdW-1:0]]) begin
        sel_found = 1'b1;
        sel_id    = cand[IdW-1:0];
      end
    end
  end

  // Reset masks the handshake outputs immediately, so a mid-burst reset
  // never produces a write in the reset cycle.
  assign in_burst      = (state_q == StBurst) && !rst;
  assign grantee_valid = req_valid[gnt_id_q];
  assign grantee_last  = req_last[gnt_id_q];
  assign beat_acc      = in_burst && grantee_valid && !fifo_full;
  assign burst_done    = beat_acc && (grantee_last || (beat_cnt_q == LastBeatCnt));

  assign gnt_valid  = in_burst;
  assign gnt_id     = gnt_id_q;
  assign fifo_wr_en = beat_acc;

  always_comb begin
    fifo_wr_data = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (gnt_id_q == IdW'(i)) begin
        fifo_wr_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Only the grantee sees ready, and only while the FIFO has room.
  always_comb begin
    req_ready = '0;
    if (in_burst) begin
      req_ready[gnt_id_q] = !fifo_full;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      gnt_id_q   <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (sel_found) begin
            gnt_id_q   <= sel_id;
            beat_cnt_q <= '0;
            state_q    <= StBurst;
          end
        end
        StBurst: begin
          if (beat_acc) begin
            beat_cnt_q <= beat_cnt_q + CntW'(1);
          end
          if (burst_done) begin
            state_q  <= StIdle;
            gnt_id_q <= '0;
            rr_ptr_q <= (gnt_id_q == LastId) ? '0 : gnt_id_q + IdW'(1);
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter (NREQ=4, MAX_BURST=4, DATA_WIDTH=8):
// a vector table, hand-written multi-cycle sequences and a randomized run,
// all compared against a behavioural model of the arbitration rules.
module tb_fifo_wr_arbiter;

  localparam int DW = 8;
  localparam int N  = 4;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]  req_last;
  logic [N-1:0]  req_ready;
  logic          fifo_full;
  logic          fifo_wr_en;
  logic [DW-1:0] fifo_wr_data;
  logic          gnt_valid;
  logic [1:0]    gnt_id;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .DATA_WIDTH(DW),
    .NREQ      (N),
    .MAX_BURST (MB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .fifo_full   (fifo_full),
    .fifo_wr_en  (fifo_wr_en),
    .fifo_wr_data(fifo_wr_data),
    .gnt_valid   (gnt_valid),
    .gnt_id      (gnt_id)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Vector table
  typedef struct {
    logic         rst;
    logic [N-1:0] valid;
    logic [N-1:0] last;
    logic         full;
    logic [N-1:0] e_ready;
    logic         e_wr;
    logic [7:0]   e_data;
    logic         e_gv;
    logic [1:0]   e_gid;
  } vec_t;

  vec_t tab [16];

  task automatic set_row(input int r, input logic rs, input logic [3:0] v, input logic [3:0] l,
                         input logic f, input logic [3:0] er, input logic ew,
                         input logic [7:0] ed, input logic eg, input logic [1:0] ei);
    tab[r] = '{rs, v, l, f, er, ew, ed, eg, ei};
  endtask

  // Behavioural model: who owns the port, beats taken, where the search starts
  int m_busy = 0, m_owner = 0, m_cnt = 0, m_ptr = 0;

  // Producers: per-requester ring of {last, data}
  logic [8:0] pbuf [N][256];
  int  phead [N];
  int  ptail [N];
  bit  presented [N];
  bit  hold [N];
  bit  hs [N];
  bit  use_prod = 0;
  bit  use_sb = 0;
  int  pseq [N];
  int  sb_seq [N];
  int  wr_total = 0;

  // Write log and expected log
  logic [7:0] log_d [512];
  int  log_id [512];
  int  log_n = 0;
  logic [7:0] exp_d [32];
  int  exp_id [32];
  int  exp_n = 0;

  // Values sampled at the last tick
  logic         s_wr, s_gv;
  logic [N-1:0] s_ready;
  logic [1:0]   s_gid;
  logic [7:0]   s_data;

  task automatic push(input int i, input logic [7:0] d, input logic l);
    pbuf[i][ptail[i] % 256] = {l, d};
    ptail[i]++;
  endtask

  task automatic add_exp(input int id, input logic [7:0] d);
    exp_id[exp_n] = id;
    exp_d[exp_n]  = d;
    exp_n++;
  endtask

  task automatic clear_all();
    for (int i = 0; i < N; i++) begin
      phead[i] = 0;
      ptail[i] = 0;
      presented[i] = 0;
      hold[i] = 0;
    end
    log_n = 0;
    exp_n = 0;
  endtask

  task automatic drive_producers();
    logic [8:0] e;
    for (int i = 0; i < N; i++) begin
      if ((ptail[i] != phead[i]) && (presented[i] || !hold[i])) begin
        e = pbuf[i][phead[i] % 256];
        req_valid[i] = 1'b1;
        req_last[i]  = e[8];
        req_data[i*DW +: DW] = e[7:0];
        presented[i] = 1;
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
        req_data[i*DW +: DW] = '0;
      end
    end
  endtask

  task automatic tick(input bit use_tab, input int row);
    logic [N-1:0] e_ready;
    logic         e_wr;
    logic [7:0]   e_data;
    bit           found;
    if (use_prod) drive_producers();
    @(negedge clk);
    // model expectations for this cycle
    e_ready = '0;
    e_wr    = 1'b0;
    e_data  = '0;
    if (!rst && m_busy != 0) begin
      e_ready[m_owner] = !fifo_full;
      e_wr   = req_valid[m_owner] && !fifo_full;
      e_data = req_data[m_owner*DW +: DW];
    end
    chk("model_ready", req_ready, e_ready);
    chk("model_wr_en", fifo_wr_en, e_wr);
    chk("model_gnt_valid", gnt_valid, (!rst && m_busy != 0));
    chk("model_gnt_id", gnt_id, m_owner);
    if (e_wr) chk("model_wr_data", fifo_wr_data, e_data);
    if (use_tab) begin
      chk("tab_ready", req_ready, tab[row].e_ready);
      chk("tab_wr_en", fifo_wr_en, tab[row].e_wr);
      chk("tab_gnt_valid", gnt_valid, tab[row].e_gv);
      chk("tab_gnt_id", gnt_id, tab[row].e_gid);
      if (tab[row].e_wr) chk("tab_wr_data", fifo_wr_data, tab[row].e_data);
    end
    s_wr = fifo_wr_en; s_gv = gnt_valid; s_ready = req_ready;
    s_gid = gnt_id; s_data = fifo_wr_data;
    if (fifo_wr_en) begin
      log_d[log_n]  = fifo_wr_data;
      log_id[log_n] = gnt_id;
      if (log_n < 511) log_n++;
      wr_total++;
      if (use_sb) begin
        chk("sb_source", fifo_wr_data[7:6], gnt_id);
        chk("sb_order", fifo_wr_data[5:0], sb_seq[gnt_id] & 63);
        sb_seq[gnt_id]++;
      end
    end
    for (int i = 0; i < N; i++) hs[i] = use_prod && req_valid[i] && req_ready[i];
    // advance the model with the inputs seen at the coming edge
    if (rst) begin
      m_busy = 0; m_owner = 0; m_cnt = 0; m_ptr = 0;
    end else if (m_busy == 0) begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        if (!found && req_valid[(m_ptr + k) % N]) begin
          found = 1;
          m_owner = (m_ptr + k) % N;
        end
      end
      if (found) begin
        m_busy = 1;
        m_cnt = 0;
      end
    end else if (req_valid[m_owner] && !fifo_full) begin
      m_cnt++;
      if (req_last[m_owner] || m_cnt == MB) begin
        m_busy = 0;
        m_ptr = (m_owner + 1) % N;
        m_owner = 0;
      end
    end
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      if (hs[i]) begin
        phead[i]++;
        presented[i] = 0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fifo_full = 1'b0;
    tick(0, 0);
    rst = 1'b0;
    log_n = 0;
  endtask

  task automatic check_log(input string name);
    chk({name, "_count"}, log_n, exp_n);
    for (int k = 0; k < exp_n; k++) begin
      chk({name, "_id"}, log_id[k], exp_id[k]);
      chk({name, "_data"}, log_d[k], exp_d[k]);
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_last = '0;
    req_data = '0;
    fifo_full = 1'b0;
    clear_all();
    for (int i = 0; i < N; i++) begin
      pseq[i] = 0;
      sb_seq[i] = 0;
    end
    @(posedge clk);
    #1;

    // ---- table: reset with all valid, round-robin of single beats, full stall
    set_row(0,  1, 4'hF, 4'hF, 0, 4'h0, 0, 8'h00, 0, 2'd0);
    set_row(1,  1, 4'hF, 4'hF, 0, 4'h0, 0, 8'h00, 0, 2'd0);
    set_row(2,  1, 4'hF, 4'hF, 0, 4'h0, 0, 8'h00, 0, 2'd0);
    set_row(3,  0, 4'hF, 4'hF, 0, 4'h0, 0, 8'h00, 0, 2'd0);
    set_row(4,  0, 4'hF, 4'hF, 0, 4'h1, 1, 8'hA0, 1, 2'd0);
    set_row(5,  0, 4'hF, 4'hF, 0, 4'h0, 0, 8'h00, 0, 2'd0);
    set_row(6,  0, 4'hF, 4'hF, 0, 4'h2, 1, 8'hA1, 1, 2'd1);
    set_row(7,  0, 4'hF, 4'hF, 0, 4'h0, 0, 8'h00, 0, 2'd0);
    set_row(8,  0, 4'hF, 4'hF, 0, 4'h4, 1, 8'hA2, 1, 2'd2);
    set_row(9,  0, 4'hF, 4'hF, 0, 4'h0, 0, 8'h00, 0, 2'd0);
    set_row(10, 0, 4'hF, 4'hF, 0, 4'h8, 1, 8'hA3, 1, 2'd3);
    set_row(11, 0, 4'hF, 4'hF, 0, 4'h0, 0, 8'h00, 0, 2'd0);
    set_row(12, 0, 4'hF, 4'hF, 0, 4'h1, 1, 8'hA0, 1, 2'd0);
    set_row(13, 0, 4'hF, 4'hF, 0, 4'h0, 0, 8'h00, 0, 2'd0);
    set_row(14, 0, 4'hF, 4'hF, 1, 4'h0, 0, 8'h00, 1, 2'd1);
    set_row(15, 0, 4'hF, 4'hF, 0, 4'h2, 1, 8'hA1, 1, 2'd1);
    for (int r = 0; r < 16; r++) begin
      rst       = tab[r].rst;
      req_valid = tab[r].valid;
      req_last  = tab[r].last;
      fifo_full = tab[r].full;
      req_data  = 32'hA3A2A1A0;
      tick(1, r);
    end

    use_prod = 1;

    // ---- burst cap: requester 2 streams 10 beats without last, 3 also waits
    clear_all();
    for (int k = 0; k < 10; k++) push(2, 8'(8'h20 + k), 1'b0);
    push(3, 8'h30, 1'b1);
    do_reset();
    for (int c = 0; c < 20; c++) tick(0, 0);
    for (int k = 0; k < 4; k++) add_exp(2, 8'(8'h20 + k));
    add_exp(3, 8'h30);
    for (int k = 4; k < 10; k++) add_exp(2, 8'(8'h20 + k));
    check_log("burst_cap");

    // ---- back-pressure: fifo_full for 5 cycles mid-burst
    clear_all();
    for (int k = 0; k < 6; k++) push(1, 8'(8'h10 + k), (k == 5));
    push(3, 8'h30, 1'b1);
    do_reset();
    for (int c = 0; c < 20; c++) begin
      fifo_full = (c >= 4 && c <= 8);
      tick(0, 0);
      if (c >= 4 && c <= 8) begin
        chk("bp_wr_en", s_wr, 1'b0);
        chk("bp_ready", s_ready, 4'h0);
        chk("bp_gnt_id", s_gid, 2'd1);
        chk("bp_gnt_valid", s_gv, 1'b1);
      end
      if (c == 9) begin
        chk("bp_resume_wr", s_wr, 1'b1);
        chk("bp_resume_data", s_data, 8'h13);
      end
    end
    fifo_full = 1'b0;
    for (int k = 0; k < 4; k++) add_exp(1, 8'(8'h10 + k));
    add_exp(3, 8'h30);
    add_exp(1, 8'h14);
    add_exp(1, 8'h15);
    check_log("backpressure");

    // ---- sparse grantee: requester 0 idles 3 cycles between beats
    clear_all();
    for (int k = 0; k < 4; k++) push(0, 8'(8'h40 + k), (k == 3));
    push(2, 8'h50, 1'b1);
    do_reset();
    for (int c = 0; c < 14; c++) begin
      hold[0] = (c >= 2 && c <= 4);
      tick(0, 0);
      if (c >= 2 && c <= 4) begin
        chk("sparse_gnt_valid", s_gv, 1'b1);
        chk("sparse_gnt_id", s_gid, 2'd0);
        chk("sparse_wr_en", s_wr, 1'b0);
      end
    end
    hold[0] = 0;
    for (int k = 0; k < 4; k++) add_exp(0, 8'(8'h40 + k));
    add_exp(2, 8'h50);
    check_log("sparse");

    // ---- reset after beat 2 of requester 1
    clear_all();
    for (int k = 0; k < 4; k++) push(1, 8'(8'h60 + k), (k == 3));
    do_reset();
    for (int c = 0; c < 16; c++) begin
      rst = (c == 3);
      if (c == 3) begin
        push(0, 8'h70, 1'b1);
        push(3, 8'h80, 1'b1);
      end
      tick(0, 0);
      if (c == 3) begin
        chk("rstmid_wr_en", s_wr, 1'b0);
        chk("rstmid_ready", s_ready, 4'h0);
        chk("rstmid_gnt_valid", s_gv, 1'b0);
      end
      if (c == 4) chk("rstmid_idle", s_gv, 1'b0);
      if (c == 5) begin
        chk("rstmid_regrant_valid", s_gv, 1'b1);
        chk("rstmid_regrant_id", s_gid, 2'd0);
      end
    end
    rst = 1'b0;
    add_exp(1, 8'h60);
    add_exp(1, 8'h61);
    add_exp(0, 8'h70);
    add_exp(1, 8'h62);
    add_exp(1, 8'h63);
    add_exp(3, 8'h80);
    check_log("rst_mid");

    // ---- randomized traffic against the model and per-requester ordering
    clear_all();
    use_sb = 1;
    do_reset();
    wr_total = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (ptail[i] == phead[i] && $urandom_range(0, 2) == 0) begin
          int len;
          len = int'($urandom_range(1, 6));
          for (int k = 0; k < len; k++) begin
            push(i, 8'((i << 6) | (pseq[i] & 63)), (k == len - 1));
            pseq[i]++;
          end
        end
        hold[i] = ($urandom_range(0, 3) == 0);
      end
      fifo_full = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 399) == 0);
      tick(0, 0);
    end
    rst = 1'b0;
    chk("rand_progress", (wr_total > 500), 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
